// File: rtl/mult_control_unit_if.sv
// mult_control_unit_if
//   Bundles the button inputs, multiplier bit and datapath strobes exchanged
//   between the multiplier control unit and its surroundings.
//   Signals:
//     Run, ClearA_LoadB  synchronized button levels into the controller
//     M                  current multiplier bit (B[0] of the datapath)
//     Clr_Ld, ClrAX      datapath clear/load strobes
//     Add, Sub, Shift    datapath arithmetic strobes
//     Busy, Done         operation status
//   Modports:
//     master  side that drives the buttons / M and observes the strobes
//     slave   the control unit itself
interface mult_control_unit_if;
    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Clr_Ld;
    logic ClrAX;
    logic Add;
    logic Sub;
    logic Shift;
    logic Busy;
    logic Done;

    modport master (
        output Run, ClearA_LoadB, M,
        input  Clr_Ld, ClrAX, Add, Sub, Shift, Busy, Done
    );

    modport slave (
        input  Run, ClearA_LoadB, M,
        output Clr_Ld, ClrAX, Add, Sub, Shift, Busy, Done
    );
endinterface

// File: rtl/mult_control_unit.sv
// mult_control_unit
//   Sequencing FSM for the N-bit signed shift-add multiplier datapath
//   (registers X:A:B plus adder/subtractor). Converts the Run and
//   ClearA_LoadB buttons into per-cycle datapath strobes and performs
//   exactly one multiply per Run press.
//   Parameters:
//     N      multiplier width = number of add/shift iterations (N >= 2)
//   Ports:
//     Clk    system clock, rising edge
//     Reset  synchronous, active-high reset; forces all outputs to 0
//     bus    mult_control_unit_if.slave (Run, ClearA_LoadB, M in;
//            Clr_Ld, ClrAX, Add, Sub, Shift, Busy, Done out)
//   Configuration:
//     MULT_CTRL_AUTOCLEAR_EN  when defined, every multiply starts with one
//                             ClrAX cycle (CLEAR state). When undefined the
//                             CLEAR state does not exist, ClrAX is 0 and IDLE
//                             goes straight to ADD.
module mult_control_unit #(
    parameter int N = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    mult_control_unit_if.slave  bus
);

    localparam int              CW   = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

`ifdef MULT_CTRL_AUTOCLEAR_EN
    typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HOLD} state_t;
    localparam state_t START = CLEAR;
`else
    typedef enum logic [2:0] {IDLE, ADD, SHIFT, HOLD} state_t;
    localparam state_t START = ADD;
`endif

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;

    logic clr_ld, clrax, add, sub, shift, busy, done;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_ld   = 1'b0;
        clrax    = 1'b0;
        add      = 1'b0;
        sub      = 1'b0;
        shift    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state)
            IDLE: begin
                clr_ld = bus.ClearA_LoadB;
                // Load request wins over Run in the same cycle.
                if (!bus.ClearA_LoadB && bus.Run) begin
                    cnt_nx   = '0;
                    state_nx = START;
                end
            end
`ifdef MULT_CTRL_AUTOCLEAR_EN
            CLEAR: begin
                busy     = 1'b1;
                clrax    = 1'b1;
                state_nx = ADD;
            end
`endif
            ADD: begin
                busy = 1'b1;
                // Final iteration weighs the sign bit of the multiplier: subtract.
                if (bus.M) begin
                    if (cnt == LAST) sub = 1'b1;
                    else             add = 1'b1;
                end
                state_nx = SHIFT;
            end
            SHIFT: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (cnt == LAST) begin
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end else begin
                    cnt_nx   = cnt + CW'(1);
                    state_nx = ADD;
                end
            end
            HOLD: begin
                done = 1'b1;
                if (!bus.Run) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are forced low for the whole cycle Reset is asserted.
    assign bus.Clr_Ld = clr_ld & ~Reset;
    assign bus.ClrAX  = clrax  & ~Reset;
    assign bus.Add    = add    & ~Reset;
    assign bus.Sub    = sub    & ~Reset;
    assign bus.Shift  = shift  & ~Reset;
    assign bus.Busy   = busy   & ~Reset;
    assign bus.Done   = done   & ~Reset;

endmodule

// File: tb/tb_mult_control_unit.sv
// tb_mult_control_unit
//   Self-checking bench for mult_control_unit (N=8). A cycle-offset model of
//   the multiply schedule predicts every output on every cycle; directed
//   scenarios add literal expectations (pulse counts, latency, a datapath
//   product), followed by a randomized phase.
module tb_mult_control_unit;

    localparam int N = 8;
`ifdef MULT_CTRL_AUTOCLEAR_EN
    localparam int AC = 1;
`else
    localparam int AC = 0;
`endif
    localparam int L = 2 * N + AC;   // busy cycles per multiply

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic clb = 1'b0;
    logic m_drv = 1'b0;
    logic use_dp = 1'b0;

    always #5 clk = ~clk;

    mult_control_unit_if bus ();

    mult_control_unit #(.N(N)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    // Small datapath so the strobes can be checked against a real product.
    logic [7:0] dA, dB, sw, sreg;
    logic       dX;
    initial begin
        dA = '0; dB = '0; dX = 1'b0; sw = '0; sreg = '0;
    end
    always @(posedge clk) begin
        if (bus.Clr_Ld) begin
            dA <= '0; dX <= 1'b0; dB <= sw;
        end else if (bus.ClrAX) begin
            dA <= '0; dX <= 1'b0;
        end else if (bus.Add) begin
            {dX, dA} <= {dA[7], dA} + {sreg[7], sreg};
        end else if (bus.Sub) begin
            {dX, dA} <= {dA[7], dA} - {sreg[7], sreg};
        end else if (bus.Shift) begin
            {dX, dA, dB} <= {dX, dX, dA, dB[7:1]};
        end
    end

    assign bus.Run          = run;
    assign bus.ClearA_LoadB = clb;
    assign bus.M            = use_dp ? dB[0] : m_drv;

    // Model: 0 idle, 1 busy (mt = cycle offset into the multiply), 2 hold.
    int mstate = 0;
    int mt = 0;
    always @(posedge clk) begin
        if (rst) begin
            mstate = 0; mt = 0;
        end else begin
            case (mstate)
                0: if (!clb && run) begin mstate = 1; mt = 0; end
                1: begin
                    mt = mt + 1;
                    if (mt == L) begin mstate = 2; mt = 0; end
                end
                default: if (!run) mstate = 0;
            endcase
        end
    end

    // Pulse counters, observed mid-cycle.
    int n_clrax = 0, n_shift = 0, n_add = 0, n_sub = 0, n_busy = 0;
    always @(negedge clk) begin
        if (bus.ClrAX) n_clrax++;
        if (bus.Shift) n_shift++;
        if (bus.Add)   n_add++;
        if (bus.Sub)   n_sub++;
        if (bus.Busy)  n_busy++;
    end

    int n_checks = 0;
    int n_err = 0;

    // {Clr_Ld, ClrAX, Add, Sub, Shift, Busy, Done}
    function automatic logic [6:0] dut_out();
        return {bus.Clr_Ld, bus.ClrAX, bus.Add, bus.Sub, bus.Shift, bus.Busy, bus.Done};
    endfunction

    function automatic logic [6:0] model_out();
        logic [6:0] e = '0;
        int j, it;
        if (!rst) begin
            if (mstate == 0) begin
                e[6] = clb;
            end else if (mstate == 1) begin
                e[1] = 1'b1;
                if (AC == 1 && mt == 0) begin
                    e[5] = 1'b1;
                end else begin
                    j  = mt - AC;
                    it = j / 2;
                    if (j % 2 == 0) begin
                        e[4] = bus.M && (it < N - 1);
                        e[3] = bus.M && (it == N - 1);
                    end else begin
                        e[2] = 1'b1;
                    end
                end
            end else begin
                e[0] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: compare at the falling edge, then return slightly later so
    // the caller can drive inputs well away from the rising edge.
    task automatic step();
        logic [6:0] a, e;
        @(negedge clk);
        a = dut_out();
        e = model_out();
        n_checks++;
        if (a !== e) begin
            n_err++;
            $display("FAIL cycle_outputs: got %b expected %b (ClrLd,ClrAX,Add,Sub,Shift,Busy,Done) t=%0t",
                     a, e, $time);
        end
        #1;
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            step();
            got = bus.Done;
        end
        check("done_seen", int'(got), 1);
    endtask

    int b_clrax, b_shift, b_add, b_sub, b_busy;
    task automatic snap();
        b_clrax = n_clrax; b_shift = n_shift; b_add = n_add;
        b_sub = n_sub; b_busy = n_busy;
    endtask

    initial begin
        // 1. Reset with both buttons high, then release with Run held.
        rst = 1'b1; run = 1'b1; clb = 1'b1;
        step();
        check("reset_outs0", int'(dut_out()), 0);
        step();
        check("reset_outs1", int'(dut_out()), 0);
        clb = 1'b0; rst = 1'b0;
        step();
        check("first_busy", int'(bus.Busy), 1);
        check("first_clrax", int'(bus.ClrAX), AC);
        run = 1'b0;
        wait_done();
        step();

        // 2. M=0, single Run pulse.
        m_drv = 1'b0;
        snap();
        run = 1'b1; step(); run = 1'b0;
        wait_done();
        check("m0_clrax", n_clrax - b_clrax, AC);
        check("m0_shift", n_shift - b_shift, 8);
        check("m0_add",   n_add - b_add, 0);
        check("m0_sub",   n_sub - b_sub, 0);
`ifdef MULT_CTRL_AUTOCLEAR_EN
        check("m0_busy",  n_busy - b_busy, 17);
`else
        check("m0_busy",  n_busy - b_busy, 16);
`endif
        step();
        check("m0_idle_done", int'(bus.Done), 0);

        // 3. Datapath product: S=2, B=-1 -> X:A:B = 1FFFE.
        use_dp = 1'b1; sw = 8'hFF; sreg = 8'h02;
        clb = 1'b1; step();
        check("load_clr_ld", int'(bus.Clr_Ld), 1);
        clb = 1'b0;
        snap();
        run = 1'b1; step(); run = 1'b0;
        wait_done();
        check("m1_add",   n_add - b_add, 7);
        check("m1_sub",   n_sub - b_sub, 1);
        check("m1_shift", n_shift - b_shift, 8);
        check("product",  int'({dX, dA, dB}), 32'h1FFFE);
        step();
        use_dp = 1'b0;

        // 4. Run held for 40 cycles: exactly one multiply.
        m_drv = 1'b1;
        snap();
        run = 1'b1;
        for (int k = 0; k < 40; k++) step();
        check("held_shift", n_shift - b_shift, 8);
        check("held_done",  int'(bus.Done), 1);
        run = 1'b0; step();
        check("held_exit_done", int'(bus.Done), 0);
        check("held_exit_busy", int'(bus.Busy), 0);
        snap();
        run = 1'b1; step(); run = 1'b0;
        check("retrig_busy", int'(bus.Busy), 1);
        wait_done();
        check("retrig_shift", n_shift - b_shift, 8);
        step();

        // 5. Reset during the 5th shift.
        snap();
        run = 1'b1; step(); run = 1'b0;
        begin
            bit hit = 1'b0;
            for (int k = 0; k < 50 && !hit; k++) begin
                step();
                if (n_shift - b_shift == 5) begin rst = 1'b1; hit = 1'b1; end
            end
            check("fifth_shift_seen", int'(hit), 1);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("rst_mid_shift", n_shift - b_shift, 5);
        check("rst_mid_busy", int'(bus.Busy), 0);
        check("rst_mid_done", int'(bus.Done), 0);

        // 6. Load and Run together; load request mid-operation.
        run = 1'b1; clb = 1'b1; step();
        check("both_clr_ld", int'(bus.Clr_Ld), 1);
        check("both_busy",   int'(bus.Busy), 0);
        step();
        check("both_busy2",  int'(bus.Busy), 0);
        run = 1'b0; clb = 1'b0; step();
        run = 1'b1; step(); run = 1'b0;
        clb = 1'b1;
        step(); step();
        check("clb_busy_clr_ld", int'(bus.Clr_Ld), 0);
        check("clb_busy_busy",   int'(bus.Busy), 1);
        clb = 1'b0;
        wait_done();
        step();

        // Randomized phase, model-checked every cycle.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) run = ~run;
            clb   = ($urandom_range(0, 9) == 0);
            m_drv = 1'($urandom);
            step();
        end
        rst = 1'b1; step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
